// File: rtl/regfile_seq_pkg.sv
// rtl/regfile_seq_pkg.sv - shared op codes, FSM states and width defaults for the register-file sequencer
package regfile_seq_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - combinational ALU: op/A/B to result, zero and signed-overflow flags
module seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        result   = sum;
        overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result   = diff;
        overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOR: result = ~(a | b);
      OP_SLT: result[0] = ($signed(a) < $signed(b));
      OP_SLL: result = b << a[4:0];
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/regfile_op_sequencer.sv
// rtl/regfile_op_sequencer.sv - four-cycle read/exec/write sequencer driving a 2R1W register file
module regfile_op_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Cmd_Valid,
  output logic              Cmd_Ready,
  input  logic [2:0]        Cmd_Op,
  input  logic [ADDR_W-1:0] Cmd_Rs,
  input  logic [ADDR_W-1:0] Cmd_Rt,
  input  logic [ADDR_W-1:0] Cmd_Rd,
  output logic [ADDR_W-1:0] R_Addr_A,
  output logic [ADDR_W-1:0] R_Addr_B,
  input  logic [DATA_W-1:0] R_Data_A,
  input  logic [DATA_W-1:0] R_Data_B,
  output logic              Write_Reg,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              Done,
  output logic [DATA_W-1:0] Result,
  output logic              Zero_Flag,
  output logic              Overflow
);

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] opnd_a, opnd_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero, alu_overflow;
  logic              accept;

  assign accept = (state == IDLE) && Cmd_Valid && Cmd_Ready;

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op       (op_q),
    .a        (opnd_a),
    .b        (opnd_b),
    .result   (alu_result),
    .zero     (alu_zero),
    .overflow (alu_overflow)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Outputs are registered one edge ahead of the state they belong to.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Cmd_Ready <= 1'b1;
      Done      <= 1'b0;
      Write_Reg <= 1'b0;
      op_q      <= '0;
      R_Addr_A  <= '0;
      R_Addr_B  <= '0;
      W_Addr    <= '0;
      opnd_a    <= '0;
      opnd_b    <= '0;
      W_Data    <= '0;
      Result    <= '0;
      Zero_Flag <= 1'b1;
      Overflow  <= 1'b0;
    end else begin
      Cmd_Ready <= (state_nxt == IDLE);
      Done      <= (state == EXEC);
      // r0 is protected here rather than relying on the register file.
      Write_Reg <= (state == EXEC) && (W_Addr != '0);
      if (accept) begin
        op_q     <= Cmd_Op;
        R_Addr_A <= Cmd_Rs;
        R_Addr_B <= Cmd_Rt;
        W_Addr   <= Cmd_Rd;
      end
      if (state == READ) begin
        opnd_a <= R_Data_A;
        opnd_b <= R_Data_B;
      end
      if (state == EXEC) begin
        Result    <= alu_result;
        W_Data    <= alu_result;
        Zero_Flag <= alu_zero;
        Overflow  <= alu_overflow;
      end
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// tb/tb_regfile_op_sequencer.sv - scoreboard bench for regfile_op_sequencer with a behavioural register file
module tb_regfile_op_sequencer;

  logic        Clk;
  logic        Reset_n;
  logic        Cmd_Valid;
  logic        Cmd_Ready;
  logic [2:0]  Cmd_Op;
  logic [4:0]  Cmd_Rs, Cmd_Rt, Cmd_Rd;
  logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
  logic [31:0] R_Data_A, R_Data_B, W_Data, Result;
  logic        Write_Reg, Done, Zero_Flag, Overflow;

  logic [31:0] rf [32];
  logic        tb_we;
  logic [4:0]  tb_waddr;
  logic [31:0] tb_wdata;
  int          write_count = 0;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        zero;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic        accepted;
    logic        done_seen;
    int          lat;
    int          done_pulses;
    int          wr_cycles;
    logic        busy_ready;
    logic        ready_after;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
  } obs_t;

  exp_t sb[$];

  regfile_op_sequencer #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Cmd_Valid (Cmd_Valid),
    .Cmd_Ready (Cmd_Ready),
    .Cmd_Op    (Cmd_Op),
    .Cmd_Rs    (Cmd_Rs),
    .Cmd_Rt    (Cmd_Rt),
    .Cmd_Rd    (Cmd_Rd),
    .R_Addr_A  (R_Addr_A),
    .R_Addr_B  (R_Addr_B),
    .R_Data_A  (R_Data_A),
    .R_Data_B  (R_Data_B),
    .Write_Reg (Write_Reg),
    .W_Addr    (W_Addr),
    .W_Data    (W_Data),
    .Done      (Done),
    .Result    (Result),
    .Zero_Flag (Zero_Flag),
    .Overflow  (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural register file: combinational reads, write on rising edge; r0 is not hardwired.
  assign R_Data_A = rf[R_Addr_A];
  assign R_Data_B = rf[R_Addr_B];

  always @(posedge Clk) begin
    if (tb_we) begin
      rf[tb_waddr] <= tb_wdata;
    end else if (Write_Reg) begin
      rf[W_Addr]  <= W_Data;
      write_count <= write_count + 1;
    end
  end

  function automatic void exp_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic v);
    logic [32:0] w;
    v = 1'b0;
    r = '0;
    case (op)
      3'd0: begin w = {a[31], a} + {b[31], b}; r = w[31:0]; v = w[32] ^ w[31]; end
      3'd1: begin w = {a[31], a} - {b[31], b}; r = w[31:0]; v = w[32] ^ w[31]; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~(a | b);
      3'd6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = b << a[4:0];
    endcase
  endfunction

  task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
    tb_we    = 1'b1;
    tb_waddr = a;
    tb_wdata = d;
    @(negedge Clk);
    tb_we = 1'b0;
  endtask

  // Drives one command from a falling edge, pushes its expectation, and returns at the falling edge of cycle 4.
  task automatic run_cmd(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input bit noise, output obs_t o);
    exp_t        e;
    logic [31:0] r;
    logic        v;
    exp_alu(op, rf[rs], rf[rt], r, v);
    e.wr = (rd != 5'd0); e.addr = rd; e.data = r; e.zero = (r == 32'd0); e.ovf = v;
    sb.push_back(e);
    o.accepted = Cmd_Ready; o.done_seen = 1'b0; o.lat = 0; o.done_pulses = 0; o.wr_cycles = 0;
    o.busy_ready = 1'b0; o.ready_after = 1'b0; o.wr = 1'b0; o.addr = '0; o.data = '0;
    o.result = '0; o.zero = 1'b0; o.ovf = 1'b0;
    Cmd_Valid = 1'b1; Cmd_Op = op; Cmd_Rs = rs; Cmd_Rt = rt; Cmd_Rd = rd;
    @(posedge Clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      if (c <= 3 && Cmd_Ready) o.busy_ready = 1'b1;
      if (Write_Reg) o.wr_cycles++;
      if (Done) begin
        o.done_pulses++;
        if (!o.done_seen) begin
          o.done_seen = 1'b1; o.lat = c; o.wr = Write_Reg; o.addr = W_Addr; o.data = W_Data;
          o.result = Result; o.zero = Zero_Flag; o.ovf = Overflow;
        end
      end
      if (c == 4) o.ready_after = Cmd_Ready;
      if (c == 1 && noise) begin
        Cmd_Valid = 1'b1; Cmd_Op = 3'd0; Cmd_Rs = 5'd1; Cmd_Rt = 5'd1; Cmd_Rd = 5'd20;
      end else if (c == 1 || c == 4) begin
        Cmd_Valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    total++; if (Cmd_Ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", Cmd_Ready); else passed++;
    total++; if (Write_Reg !== 1'b0) $display("FAIL reset_write_reg got=%b exp=0", Write_Reg); else passed++;
    total++; if (Done !== 1'b0) $display("FAIL reset_done got=%b exp=0", Done); else passed++;
    total++; if (Zero_Flag !== 1'b1) $display("FAIL reset_zero got=%b exp=1", Zero_Flag); else passed++;
    total++; if ({Result, W_Data, Overflow} !== 65'd0) $display("FAIL reset_data got=%h/%h/%b exp=0", Result, W_Data, Overflow); else passed++;
    total++; if ({R_Addr_A, R_Addr_B, W_Addr} !== 15'd0) $display("FAIL reset_addr got=%h/%h/%h exp=0", R_Addr_A, R_Addr_B, W_Addr); else passed++;
    @(negedge Clk);
    Reset_n = 1'b1;
    total++; if (write_count !== 0) $display("FAIL reset_no_write got=%0d exp=0", write_count); else passed++;
  endtask

  task automatic test_add();
    obs_t o;
    exp_t e;
    set_reg(5'd1, 32'd5);
    set_reg(5'd2, 32'd7);
    run_cmd(3'd0, 5'd1, 5'd2, 5'd3, 1'b0, o);
    e = sb.pop_front();
    total++; if (!(o.accepted && o.done_seen && o.lat == 3)) $display("FAIL add_latency got=acc%b seen%b lat%0d exp=lat3", o.accepted, o.done_seen, o.lat); else passed++;
    total++; if (o.wr !== e.wr || o.addr !== e.addr) $display("FAIL add_write got=%b@%0d exp=%b@%0d", o.wr, o.addr, e.wr, e.addr); else passed++;
    total++; if (o.data !== e.data || o.data !== 32'd12) $display("FAIL add_data got=%h exp=%h", o.data, e.data); else passed++;
    total++; if (o.busy_ready !== 1'b0 || o.ready_after !== 1'b1) $display("FAIL add_ready got=busy%b after%b exp=busy0 after1", o.busy_ready, o.ready_after); else passed++;
    total++; if (o.done_pulses != 1) $display("FAIL add_done_pulse got=%0d exp=1", o.done_pulses); else passed++;
    total++; if (rf[3] !== 32'd12) $display("FAIL add_rf got=%h exp=0000000c", rf[3]); else passed++;
  endtask

  task automatic test_overflow();
    obs_t o;
    exp_t e;
    set_reg(5'd1, 32'h7FFF_FFFF);
    set_reg(5'd2, 32'd1);
    run_cmd(3'd0, 5'd1, 5'd2, 5'd4, 1'b0, o);
    e = sb.pop_front();
    total++; if (o.data !== e.data || o.data !== 32'h8000_0000) $display("FAIL ovf_add_data got=%h exp=%h", o.data, e.data); else passed++;
    total++; if (o.ovf !== e.ovf || o.ovf !== 1'b1) $display("FAIL ovf_add_flag got=%b exp=%b", o.ovf, e.ovf); else passed++;
    set_reg(5'd5, 32'd0);
    set_reg(5'd6, 32'd1);
    run_cmd(3'd1, 5'd5, 5'd6, 5'd10, 1'b0, o);
    e = sb.pop_front();
    total++; if (o.data !== e.data || o.data !== 32'hFFFF_FFFF) $display("FAIL ovf_sub_data got=%h exp=%h", o.data, e.data); else passed++;
    total++; if (o.ovf !== e.ovf || o.zero !== e.zero) $display("FAIL ovf_sub_flags got=ovf%b zero%b exp=ovf%b zero%b", o.ovf, o.zero, e.ovf, e.zero); else passed++;
  endtask

  task automatic test_r0_protect();
    obs_t o;
    exp_t e;
    int   wc;
    set_reg(5'd1, 32'd9);
    wc = write_count;
    run_cmd(3'd1, 5'd1, 5'd1, 5'd0, 1'b0, o);
    e = sb.pop_front();
    total++; if (!o.done_seen || o.result !== e.data || o.zero !== 1'b1) $display("FAIL r0_result got=seen%b %h zero%b exp=0 zero1", o.done_seen, o.result, o.zero); else passed++;
    total++; if (o.wr_cycles != 0 || write_count != wc) $display("FAIL r0_write got=%0d cycles exp=0", o.wr_cycles); else passed++;
    total++; if (rf[0] !== 32'd0) $display("FAIL r0_value got=%h exp=00000000", rf[0]); else passed++;
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    exp_t e;
    int   wc;
    set_reg(5'd1, 32'hFFFF_FFFD);
    set_reg(5'd2, 32'd3);
    set_reg(5'd20, 32'h55);
    wc = write_count;
    run_cmd(3'd6, 5'd1, 5'd2, 5'd7, 1'b1, o1);
    run_cmd(3'd7, 5'd7, 5'd2, 5'd8, 1'b0, o2);
    e = sb.pop_front();
    total++; if (o1.data !== e.data || o1.data !== 32'd1) $display("FAIL b2b_slt got=%h exp=%h", o1.data, e.data); else passed++;
    e = sb.pop_front();
    total++; if (!o2.accepted || !o2.done_seen || o2.lat != 3) $display("FAIL b2b_accept got=acc%b lat%0d exp=acc1 lat3", o2.accepted, o2.lat); else passed++;
    total++; if (o2.data !== e.data || o2.data !== 32'd6) $display("FAIL b2b_sll got=%h exp=%h", o2.data, e.data); else passed++;
    repeat (4) @(negedge Clk);
    total++; if (rf[20] !== 32'h55 || write_count != wc + 2) $display("FAIL b2b_busy_ignored got=r20 %h writes %0d exp=r20 55 writes %0d", rf[20], write_count - wc, 2); else passed++;
    total++; if (rf[8] !== 32'd6) $display("FAIL b2b_rf got=%h exp=00000006", rf[8]); else passed++;
  endtask

  task automatic test_reset_mid_op();
    obs_t o;
    exp_t e;
    int   wc;
    int   wr_seen;
    set_reg(5'd1, 32'd1);
    set_reg(5'd2, 32'd2);
    set_reg(5'd9, 32'hABCD);
    wc = write_count;
    wr_seen = 0;
    Cmd_Valid = 1'b1; Cmd_Op = 3'd0; Cmd_Rs = 5'd1; Cmd_Rt = 5'd2; Cmd_Rd = 5'd9;
    @(posedge Clk);
    @(negedge Clk);
    Cmd_Valid = 1'b0;
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    total++; if (Cmd_Ready !== 1'b1 || Write_Reg !== 1'b0 || Done !== 1'b0) $display("FAIL midrst_outputs got=rdy%b wr%b done%b exp=rdy1 wr0 done0", Cmd_Ready, Write_Reg, Done); else passed++;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      if (Write_Reg) wr_seen++;
    end
    Reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      if (Write_Reg) wr_seen++;
    end
    total++; if (wr_seen != 0 || write_count != wc || rf[9] !== 32'hABCD) $display("FAIL midrst_no_write got=wr%0d r9 %h exp=wr0 r9 0000abcd", wr_seen, rf[9]); else passed++;
    total++; if (Cmd_Ready !== 1'b1) $display("FAIL midrst_idle got=%b exp=1", Cmd_Ready); else passed++;
    run_cmd(3'd0, 5'd1, 5'd2, 5'd9, 1'b0, o);
    e = sb.pop_front();
    total++; if (!o.done_seen || o.data !== e.data || rf[9] !== 32'd3) $display("FAIL midrst_recover got=%h r9 %h exp=%h", o.data, rf[9], e.data); else passed++;
  endtask

  initial begin
    Reset_n = 1'b0; Cmd_Valid = 1'b0; Cmd_Op = '0; Cmd_Rs = '0; Cmd_Rt = '0; Cmd_Rd = '0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 32; i++) set_reg(i[4:0], 32'd0);
    test_reset();
    test_add();
    test_overflow();
    test_r0_protect();
    test_back_to_back();
    test_reset_mid_op();
    total++; if (sb.size() != 0) $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
